coin_acceptor: RTL and testbench

Sequential front end that collects customer coins before the combinational change calculator runs. Accepts pentagons (5), triangles (3) and circles (1) one per handshake. Accumulates Paid against a latched Cost and maintains the 2-bit coin inventory. Presents Paid, Cost and inventory to the change calculator, then debits the coins that were dispensed as change when the transaction is acknowledged.

---
 rtl/coin_acceptor.sv | 229 ++++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin collection front end feeding the change calculator
// Optional COLLECT_TIMEOUT_EN: auto-cancel after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_acceptor #(
  parameter logic [1:0] INIT_PENTAGONS = 2'd1,
  parameter logic [1:0] INIT_TRIANGLES = 2'd1,
  parameter logic [1:0] INIT_CIRCLES   = 2'd1,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       Start,
  input  logic [3:0] Cost,
  input  logic       CoinValid,
  input  logic [1:0] CoinType,
  output logic       CoinReady,
  input  logic       Cancel,
  input  logic       SettleAck,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
  output logic [3:0] Paid,
  output logic [3:0] CostLatched,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic       SettleValid,
  output logic       CoinAccepted,
  output logic       CoinRejected,
  output logic       Refund
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SETTLE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [1:0] snap_pent;
  logic [1:0] snap_tria;
  logic [1:0] snap_circ;

  logic [3:0] paid_d;
  logic [3:0] cost_d;
  logic [1:0] pent_d;
  logic [1:0] tria_d;
  logic [1:0] circ_d;
  logic [1:0] snap_pent_d;
  logic [1:0] snap_tria_d;
  logic [1:0] snap_circ_d;
  logic       acc_d;
  logic       rej_d;
  logic       refund_d;

  logic       in_collect;
  logic       start_ok;
  logic       coin_xfer;
  logic       abort;
  logic       coin_bad;
  logic       coin_ok;
  logic       coin_rej;
  logic       timeout_hit;
  logic [2:0] coin_value;
  logic [1:0] coin_inv;
  logic [4:0] paid_sum;

  // Saturating debit of one inventory count by the coins of value coin_val handed out.
  function automatic logic [1:0] debit(input logic [1:0] cnt, input logic [2:0] coin_val,
                                       input logic [2:0] first, input logic [2:0] second);
    logic [1:0] n;
    n = {1'b0, first == coin_val} + {1'b0, second == coin_val};
    return (cnt > n) ? cnt - n : 2'd0;
  endfunction

  assign in_collect = (state == S_COLLECT);
  assign start_ok   = (state == S_IDLE) && Start && (Cost != 4'd0);
  assign coin_xfer  = CoinValid && CoinReady;
  assign abort      = in_collect && (Cancel || timeout_hit);

  always_comb begin
    coin_value = 3'd0;
    coin_inv   = 2'd0;
    case (CoinType)
      2'b01: begin coin_value = 3'd1; coin_inv = Circles;   end
      2'b10: begin coin_value = 3'd3; coin_inv = Triangles; end
      2'b11: begin coin_value = 3'd5; coin_inv = Pentagons; end
      default: begin coin_value = 3'd0; coin_inv = 2'd0;   end
    endcase
  end

  // Five-bit sum so an overflowing coin is refused rather than wrapping Paid.
  assign paid_sum = {1'b0, Paid} + {2'b00, coin_value};
  assign coin_bad = (CoinType == 2'b00) || (coin_inv == 2'd3) || (paid_sum > 5'd15);
  assign coin_ok  = coin_xfer && !abort && !coin_bad;
  assign coin_rej = coin_xfer && !abort && coin_bad;

`ifdef COLLECT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (!reset_L || !in_collect || coin_xfer) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = in_collect && !coin_xfer && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (coin_ok && (paid_sum[3:0] >= CostLatched)) begin
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (SettleAck) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    paid_d      = Paid;
    cost_d      = CostLatched;
    pent_d      = Pentagons;
    tria_d      = Triangles;
    circ_d      = Circles;
    snap_pent_d = snap_pent;
    snap_tria_d = snap_tria;
    snap_circ_d = snap_circ;
    acc_d       = 1'b0;
    rej_d       = 1'b0;
    refund_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          cost_d      = Cost;
          paid_d      = 4'd0;
          snap_pent_d = Pentagons;
          snap_tria_d = Triangles;
          snap_circ_d = Circles;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          pent_d   = snap_pent;
          tria_d   = snap_tria;
          circ_d   = snap_circ;
          paid_d   = 4'd0;
          refund_d = 1'b1;
        end else if (coin_ok) begin
          paid_d = paid_sum[3:0];
          acc_d  = 1'b1;
          case (CoinType)
            2'b11:   pent_d = Pentagons + 2'd1;
            2'b10:   tria_d = Triangles + 2'd1;
            default: circ_d = Circles + 2'd1;
          endcase
        end else if (coin_rej) begin
          rej_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (SettleAck) begin
          pent_d = debit(Pentagons, 3'd5, FirstCoin, SecondCoin);
          tria_d = debit(Triangles, 3'd3, FirstCoin, SecondCoin);
          circ_d = debit(Circles,   3'd1, FirstCoin, SecondCoin);
          paid_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      Paid         <= 4'd0;
      CostLatched  <= 4'd0;
      Pentagons    <= INIT_PENTAGONS;
      Triangles    <= INIT_TRIANGLES;
      Circles      <= INIT_CIRCLES;
      snap_pent    <= INIT_PENTAGONS;
      snap_tria    <= INIT_TRIANGLES;
      snap_circ    <= INIT_CIRCLES;
      CoinReady    <= 1'b0;
      SettleValid  <= 1'b0;
      CoinAccepted <= 1'b0;
      CoinRejected <= 1'b0;
      Refund       <= 1'b0;
    end else begin
      Paid         <= paid_d;
      CostLatched  <= cost_d;
      Pentagons    <= pent_d;
      Triangles    <= tria_d;
      Circles      <= circ_d;
      snap_pent    <= snap_pent_d;
      snap_tria    <= snap_tria_d;
      snap_circ    <= snap_circ_d;
      CoinReady    <= (state_next == S_COLLECT);
      SettleValid  <= (state_next == S_SETTLE);
      CoinAccepted <= acc_d;
      CoinRejected <= rej_d;
      Refund       <= refund_d;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor against a behavioural model
module tb_coin_acceptor;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Cost = 4'd0;
  logic       CoinValid = 1'b0;
  logic [1:0] CoinType = 2'd0;
  logic       Cancel = 1'b0;
  logic       SettleAck = 1'b0;
  logic [2:0] FirstCoin = 3'd0;
  logic [2:0] SecondCoin = 3'd0;
  logic       CoinReady;
  logic [3:0] Paid;
  logic [3:0] CostLatched;
  logic [1:0] Pentagons;
  logic [1:0] Triangles;
  logic [1:0] Circles;
  logic       SettleValid;
  logic       CoinAccepted;
  logic       CoinRejected;
  logic       Refund;

  coin_acceptor dut (
    .clock(clock), .reset_L(reset_L), .Start(Start), .Cost(Cost),
    .CoinValid(CoinValid), .CoinType(CoinType), .CoinReady(CoinReady),
    .Cancel(Cancel), .SettleAck(SettleAck), .FirstCoin(FirstCoin),
    .SecondCoin(SecondCoin), .Paid(Paid), .CostLatched(CostLatched),
    .Pentagons(Pentagons), .Triangles(Triangles), .Circles(Circles),
    .SettleValid(SettleValid), .CoinAccepted(CoinAccepted),
    .CoinRejected(CoinRejected), .Refund(Refund)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pulse events; kind is one-hot {Refund, CoinRejected, CoinAccepted}.
  typedef struct {
    int kind;
    int paid;
    int p;
    int t;
    int c;
    int sv;
  } ev_t;
  ev_t q[$];

  // Reference model: 0 idle, 1 collecting, 2 waiting for settle; inventory [circle, triangle, pentagon].
  int m_state = 0;
  int m_paid = 0;
  int m_cost = 0;
  int m_inv[3] = '{1, 1, 1};
  int m_snap[3] = '{1, 1, 1};

  function automatic int coin_val(input int ty);
    case (ty)
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic push_ev(input int kind);
    ev_t e;
    e.kind = kind;
    e.paid = m_paid;
    e.p = m_inv[2];
    e.t = m_inv[1];
    e.c = m_inv[0];
    e.sv = (m_state == 2) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic model_step(input bit rst, input bit st, input int cost, input bit cv,
                            input int ty, input bit can, input bit ack, input int f, input int s);
    int v;
    int n;
    if (rst) begin
      m_state = 0;
      m_paid = 0;
      m_cost = 0;
      m_inv = '{1, 1, 1};
      return;
    end
    case (m_state)
      0: if (st && cost != 0) begin
        m_cost = cost;
        m_paid = 0;
        m_snap = m_inv;
        m_state = 1;
      end
      1: if (can) begin
        m_inv = m_snap;
        m_paid = 0;
        m_state = 0;
        push_ev(4);
      end else if (cv) begin
        v = coin_val(ty);
        if (ty == 0 || m_inv[ty-1] == 3 || m_paid + v > 15) begin
          push_ev(2);
        end else begin
          m_paid += v;
          m_inv[ty-1]++;
          if (m_paid >= m_cost) m_state = 2;
          push_ev(1);
        end
      end
      default: if (ack) begin
        for (int k = 0; k < 3; k++) begin
          n = ((f == coin_val(k + 1)) ? 1 : 0) + ((s == coin_val(k + 1)) ? 1 : 0);
          m_inv[k] = (m_inv[k] > n) ? m_inv[k] - n : 0;
        end
        m_paid = 0;
        m_state = 0;
      end
    endcase
  endtask

  task automatic drive(input bit rst, input bit st, input int cost, input bit cv, input int ty,
                       input bit can, input bit ack, input int f, input int s);
    @(negedge clock);
    #1;
    check("pulse_missing", q.size(), 0);
    q.delete();
    reset_L = !rst;
    Start = st;
    Cost = cost[3:0];
    CoinValid = cv;
    CoinType = ty[1:0];
    Cancel = can;
    SettleAck = ack;
    FirstCoin = f[2:0];
    SecondCoin = s[2:0];
    @(posedge clock);
    model_step(rst, st, cost, cv, ty, can, ack, f, s);
    #1;
    reset_L = 1'b1;
    Start = 1'b0;
    CoinValid = 1'b0;
    Cancel = 1'b0;
    SettleAck = 1'b0;
    check("paid", Paid, m_paid);
    check("cost_latched", CostLatched, m_cost);
    check("pentagons", Pentagons, m_inv[2]);
    check("triangles", Triangles, m_inv[1]);
    check("circles", Circles, m_inv[0]);
    check("coin_ready", CoinReady, (m_state == 1) ? 1 : 0);
    check("settle_valid", SettleValid, (m_state == 2) ? 1 : 0);
  endtask

  task automatic do_reset();                drive(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_start(input int c);     drive(0, 1, c, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_coin(input int ty);     drive(0, 0, 0, 1, ty, 0, 0, 0, 0); endtask
  task automatic do_idle();                 drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_cancel(input int ty);   drive(0, 0, 0, 1, ty, 1, 0, 0, 0); endtask
  task automatic do_ack(input int f, input int s); drive(0, 0, 0, 0, 0, 0, 1, f, s); endtask

  always @(negedge clock) begin
    if (CoinAccepted || CoinRejected || Refund) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got acc=%0d rej=%0d refund=%0d, none expected at %0t",
                 CoinAccepted, CoinRejected, Refund, $time);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("ev_kind", {29'd0, Refund, CoinRejected, CoinAccepted}, e.kind);
        check("ev_paid", Paid, e.paid);
        check("ev_pentagons", Pentagons, e.p);
        check("ev_triangles", Triangles, e.t);
        check("ev_circles", Circles, e.c);
        check("ev_settle_valid", SettleValid, e.sv);
      end
    end
  end

  int picks[7] = '{0, 1, 3, 5, 2, 4, 7};

  initial begin
    int r;
    do_reset();
    do_reset();
    check("reset_acc", CoinAccepted, 0);
    check("reset_rej", CoinRejected, 0);
    check("reset_refund", Refund, 0);

    // Pentagon then triangle against cost 7, then change of one circle.
    do_start(7);
    do_coin(3);
    do_coin(2);
    do_ack(1, 0);
    // Settles on the first pentagon; later coins are ignored.
    do_start(4);
    do_coin(3);
    do_coin(3);
    do_coin(3);
    do_ack(1, 0);
    // Cancel beats a coin offered on the same cycle.
    do_reset();
    do_start(9);
    do_coin(2);
    do_coin(1);
    do_cancel(3);
    // Fill the pentagon slot, then overflow and invalid-type rejects.
    do_start(15);
    do_coin(3);
    do_coin(3);
    do_coin(3);
    do_coin(2);
    do_coin(0);
    do_coin(3);
    do_cancel(0);
    // Exact payment and a 0/0 acknowledge.
    do_start(3);
    do_coin(2);
    do_ack(0, 0);
    // Zero-cost start is ignored; reset mid-collect gives no refund.
    do_start(0);
    do_start(5);
    do_coin(1);
    drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
    // Without the timeout feature COLLECT waits indefinitely.
    do_start(9);
    for (int i = 0; i < 100; i++) do_idle();
    do_cancel(0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      case (m_state)
        0: drive(0, r < 85, (r < 10) ? 0 : $urandom_range(1, 15), r > 90, $urandom_range(0, 3),
                 r > 95, 0, 0, 0);
        1: if (r < 5) do_cancel($urandom_range(0, 3));
           else if (r < 8) drive(1, 0, 0, 1, $urandom_range(0, 3), 1, 0, 0, 0);
           else if (r < 20) drive(0, 1, $urandom_range(1, 15), 0, 0, 0, 0, 0, 0);
           else drive(0, 0, 0, r < 85, $urandom_range(0, 3), 0, 0, 0, 0);
        default: if (r < 70) do_ack(picks[$urandom_range(0, 6)], picks[$urandom_range(0, 6)]);
                 else drive(0, 1, 6, 1, 3, 1, 0, 0, 0);
      endcase
    end

    @(negedge clock);
    #1;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
